ntt_stream_io: RTL

Streaming front/back end for the radix-2 NTT/INTT core. The block accepts a frame of N coefficients over a valid/ready input stream, reduces each one mod Q and writes it into the shared coefficient BRAM. It then hands the BRAM to the core and pulses its start. When the core reports completion, it reads the N results back and emits them on a valid/ready output stream.

---
 rtl/ntt_pkg.sv | 29 ++
 rtl/ntt_mod_reduce.sv | 12 +
 rtl/ntt_stream_io.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants, stream I/O state encoding and index bit-reversal helper.
package ntt_pkg;

  localparam int unsigned Q      = 7681;
  localparam int unsigned N      = 8;
  localparam int unsigned N_INV  = 6721;  // 8 * 6721 = 1 mod 7681
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_KICK,
    ST_WAIT_NTT,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_CAPT,
    ST_SEND
  } io_state_t;

  // Reverse the low 'bits' bits of v (bits <= 8); upper bits come back zero.
  function automatic logic [7:0] bitrev(input logic [7:0] v, input int unsigned bits);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r >> (32'(8) - bits);
  endfunction

endpackage

// File: rtl/ntt_mod_reduce.sv
// Combinational unsigned 32-bit remainder modulo Q; result is always < Q.
module ntt_mod_reduce #(
  parameter int unsigned Q = 7681
) (
  input  logic [31:0] i_a,
  output logic [31:0] o_rem_c
);

  // Constant-divisor remainder, zero-extended to the full word.
  assign o_rem_c = i_a % 32'(Q);

endmodule

// File: rtl/ntt_stream_io.sv
// Stream loader/unloader around the shared NTT coefficient BRAM.
// Loads one frame of N reduced coefficients, kicks the core, then streams
// the results back out. Define NTT_STREAM_IO_BITREV_EN to unload in
// bit-reversed index order instead of natural order.
module ntt_stream_io #(
  parameter int unsigned Q      = ntt_pkg::Q,
  parameter int unsigned N      = ntt_pkg::N,
  parameter int unsigned ADDR_W = ntt_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              m_last,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              coeff_we,
  output logic [31:0]       coeff_din,
  input  logic [31:0]       coeff_dout,
  output logic              bram_sel,
  output logic              ntt_start,
  input  logic              ntt_done,
  output logic              err_len
);

  import ntt_pkg::*;

  localparam int unsigned LOG_N = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = LOG_N;

  io_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_s_ready, w_s_ready_nxt;
  logic               r_m_valid, w_m_valid_nxt;
  logic [31:0]        r_m_data, w_m_data_nxt;
  logic               r_m_last, w_m_last_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_we, w_we_nxt;
  logic [31:0]        r_din, w_din_nxt;
  logic               r_bram_sel, w_bram_sel_nxt;
  logic               r_ntt_start, w_ntt_start_nxt;
  logic               r_err_len, w_err_len_nxt;

  logic [31:0]        w_red;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_idx_last;

  // Unload address for a given beat index.
  function automatic logic [ADDR_W-1:0] out_addr(input logic [IDX_W-1:0] i);
`ifdef NTT_STREAM_IO_BITREV_EN
    return ADDR_W'(bitrev(8'(i), LOG_N));
`else
    return ADDR_W'(i);
`endif
  endfunction

  ntt_mod_reduce #(.Q(Q)) u_mod_reduce (
    .i_a     (s_data),
    .o_rem_c (w_red)
  );

  assign w_in_hs    = (r_state == ST_LOAD) && r_s_ready && s_valid;
  assign w_out_hs   = (r_state == ST_SEND) && r_m_valid && m_ready;
  assign w_idx_last = (r_idx == IDX_W'(N - 1));

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_idx       <= '0;
      r_s_ready   <= 1'b1;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_din       <= '0;
      r_bram_sel  <= 1'b0;
      r_ntt_start <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_m_data    <= w_m_data_nxt;
      r_m_last    <= w_m_last_nxt;
      r_addr      <= w_addr_nxt;
      r_we        <= w_we_nxt;
      r_din       <= w_din_nxt;
      r_bram_sel  <= w_bram_sel_nxt;
      r_ntt_start <= w_ntt_start_nxt;
      r_err_len   <= w_err_len_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_s_ready_nxt   = r_s_ready;
    w_m_valid_nxt   = r_m_valid;
    w_m_data_nxt    = r_m_data;
    w_m_last_nxt    = r_m_last;
    w_addr_nxt      = r_addr;
    w_we_nxt        = 1'b0;
    w_din_nxt       = r_din;
    w_bram_sel_nxt  = r_bram_sel;
    w_ntt_start_nxt = 1'b0;
    w_err_len_nxt   = r_err_len;

    unique case (r_state)
      ST_LOAD: begin
        w_s_ready_nxt = 1'b1;
        if (w_in_hs) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = ADDR_W'(r_idx);
          w_din_nxt  = w_red;
          if (r_idx == '0) begin
            w_err_len_nxt = 1'b0;
          end
          if (w_idx_last) begin
            // Full frame: proceed even if s_last was missing, but flag it.
            w_state_nxt   = ST_KICK;
            w_s_ready_nxt = 1'b0;
            w_idx_nxt     = '0;
            if (!s_last) begin
              w_err_len_nxt = 1'b1;
            end
          end else if (s_last) begin
            // Short frame: drop it and restart at address 0.
            w_err_len_nxt = 1'b1;
            w_idx_nxt     = '0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      ST_KICK: begin
        w_s_ready_nxt   = 1'b0;
        w_bram_sel_nxt  = 1'b1;
        w_ntt_start_nxt = 1'b1;
        w_state_nxt     = ST_WAIT_NTT;
      end
      ST_WAIT_NTT: begin
        w_bram_sel_nxt = 1'b1;
        if (ntt_done) begin
          w_bram_sel_nxt = 1'b0;
          w_idx_nxt      = '0;
          w_addr_nxt     = out_addr('0);
          w_state_nxt    = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        w_addr_nxt  = out_addr(r_idx);
        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        w_state_nxt = ST_RD_CAPT;
      end
      ST_RD_CAPT: begin
        w_m_data_nxt  = coeff_dout;
        w_m_valid_nxt = 1'b1;
        w_m_last_nxt  = w_idx_last;
        w_state_nxt   = ST_SEND;
      end
      ST_SEND: begin
        if (w_out_hs) begin
          w_m_valid_nxt = 1'b0;
          w_m_last_nxt  = 1'b0;
          if (w_idx_last) begin
            w_idx_nxt     = '0;
            w_s_ready_nxt = 1'b1;
            w_state_nxt   = ST_LOAD;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_addr_nxt  = out_addr(r_idx + IDX_W'(1));
            w_state_nxt = ST_RD_ADDR;
          end
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign coeff_addr = r_addr;
  assign coeff_we   = r_we;
  assign coeff_din  = r_din;
  assign bram_sel   = r_bram_sel;
  assign ntt_start  = r_ntt_start;
  assign err_len    = r_err_len;

endmodule
